// File: rtl/keypad_pkg.sv
// Shared types, sizes and key codes for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    HOLD    = 2'd2
  } kp_state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Row 0 driven low; the other rows are rotations of this pattern.
  localparam logic [3:0] ROW_IDLE = 4'b1110;

  // Key codes are row*4 + col; names give the legend printed on each key.
  localparam logic [3:0] KEY_D1  = 4'h0;
  localparam logic [3:0] KEY_D2  = 4'h1;
  localparam logic [3:0] KEY_D3  = 4'h2;
  localparam logic [3:0] KEY_ADD = 4'h3;
  localparam logic [3:0] KEY_D4  = 4'h4;
  localparam logic [3:0] KEY_D5  = 4'h5;
  localparam logic [3:0] KEY_D6  = 4'h6;
  localparam logic [3:0] KEY_SUB = 4'h7;
  localparam logic [3:0] KEY_D7  = 4'h8;
  localparam logic [3:0] KEY_D8  = 4'h9;
  localparam logic [3:0] KEY_D9  = 4'hA;
  localparam logic [3:0] KEY_MUL = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_D0  = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_DIV = 4'hF;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } col_hit_t;

  // Lowest-index low column wins when several keys in a row are pressed.
  function automatic col_hit_t lowest_low_col(input logic [NUM_COLS-1:0] cols);
    col_hit_t r;
    r.hit = 1'b0;
    r.idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) begin
        r.hit = 1'b1;
        r.idx = 2'(i);
      end
    end
    return r;
  endfunction

  // Active-low one-cold row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return ROW_IDLE;
      2'd1:    return {ROW_IDLE[2:0], ROW_IDLE[3]};
      2'd2:    return {ROW_IDLE[1:0], ROW_IDLE[3:2]};
      default: return {ROW_IDLE[0], ROW_IDLE[3:1]};
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Row-dwell prescaler: one-cycle tick every SCAN_TICKS clocks.
module scan_tick_gen #(
  parameter int SCAN_TICKS = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(SCAN_TICKS);
  localparam logic [CW-1:0] TC = CW'(SCAN_TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TC);

  // Free-running 0..SCAN_TICKS-1 counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and a
// valid/ready key output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SCAN    | rotating rows, waiting for a low column on a tick
// CONFIRM | row held, counting consecutive matching samples of candidate
// HOLD    | key delivered, row held, counting consecutive release samples
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_SCANS);

  logic [3:0]    col_s1, col_s2;
  logic          tick;
  kp_state_e     state, state_nx;
  logic [1:0]    row_idx, row_idx_nx;
  logic [1:0]    cand_row, cand_row_nx;
  logic [1:0]    cand_col, cand_col_nx;
  logic [DW-1:0] db_cnt, db_cnt_nx, db_inc;
  logic          deliver;
  col_hit_t      hit;

  scan_tick_gen #(.SCAN_TICKS(SCAN_TICKS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous column inputs (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  assign hit      = lowest_low_col(col_s2);
  assign db_inc   = db_cnt + 1'b1;
  assign row_out  = row_drive(row_idx);
  assign key_held = (state == HOLD);

  // Next-state logic; only tick cycles look at the columns.
  always_comb begin
    state_nx    = state;
    row_idx_nx  = row_idx;
    cand_row_nx = cand_row;
    cand_col_nx = cand_col;
    db_cnt_nx   = db_cnt;
    deliver     = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit.hit) begin
            cand_row_nx = row_idx;
            cand_col_nx = hit.idx;
            if (DEBOUNCE_SCANS <= 1) begin
              deliver   = 1'b1;
              state_nx  = HOLD;
              db_cnt_nx = '0;
            end else begin
              db_cnt_nx = DW'(1);
              state_nx  = CONFIRM;
            end
          end else begin
            row_idx_nx = row_idx + 2'd1;
          end
        end
        CONFIRM: begin
          if (hit.hit && hit.idx == cand_col) begin
            if (db_inc == DB_TC) begin
              deliver   = 1'b1;
              state_nx  = HOLD;
              db_cnt_nx = '0;
            end else begin
              db_cnt_nx = db_inc;
            end
          end else begin
            db_cnt_nx  = '0;
            state_nx   = SCAN;
            row_idx_nx = row_idx + 2'd1;
          end
        end
        HOLD: begin
          if (col_s2[cand_col]) begin
            if (db_inc == DB_TC) begin
              db_cnt_nx  = '0;
              state_nx   = SCAN;
              row_idx_nx = row_idx + 2'd1;
            end else begin
              db_cnt_nx = db_inc;
            end
          end else begin
            db_cnt_nx = '0;
          end
        end
        default: begin
          state_nx  = SCAN;
          db_cnt_nx = '0;
        end
      endcase
    end
  end

  // FSM, row and candidate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      row_idx  <= 2'd0;
      cand_row <= 2'd0;
      cand_col <= 2'd0;
      db_cnt   <= '0;
    end else begin
      state    <= state_nx;
      row_idx  <= row_idx_nx;
      cand_row <= cand_row_nx;
      cand_col <= cand_col_nx;
      db_cnt   <= db_cnt_nx;
    end
  end

  // Output handshake: an accept in the delivery cycle frees the slot for the new key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= deliver & key_valid & ~key_ready;
      if (deliver && (!key_valid || key_ready)) begin
        key_code  <= {cand_row_nx, cand_col_nx};
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a keypad matrix model and a
// behavioural reference of scanning, debouncing and the key handshake.
module tb_keypad_scanner;

  localparam int ST = 8;
  localparam int DB = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overrun;
  logic [15:0] mask;

  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int ov_cnt = 0;
  bit prev_v = 0;

  // reference model state
  int       m_row, m_mode, m_match, m_cand, m_cyc, m_code;
  bit       m_valid, m_ovr;
  bit [3:0] m_s1, m_s2;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (mask[r*4 + c]) col_in[c] = 1'b0;
  end

  function automatic bit [3:0] matrix_cols(input logic [15:0] mk, input int row);
    bit [3:0] v = 4'hF;
    for (int c = 0; c < 4; c++) if (mk[row*4 + c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_mode = 0; m_match = 0; m_cand = 0; m_cyc = 0; m_code = 0;
    m_valid = 0; m_ovr = 0; m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  // one clock edge of the reference, using pre-edge inputs
  task automatic model_step();
    bit [3:0] samp;
    bit tick, acc, deliver;
    int low;
    if (rst) begin
      model_reset();
      return;
    end
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = matrix_cols(mask, m_row);
    tick = ((m_cyc % ST) == ST - 1);
    m_cyc++;
    acc = m_valid && key_ready;
    deliver = 0;
    if (tick) begin
      low = -1;
      for (int c = 3; c >= 0; c--) if (!samp[c]) low = c;
      if (m_mode == 0) begin
        if (low >= 0) begin
          m_cand = m_row * 4 + low;
          m_match = 1;
          if (m_match >= DB) begin deliver = 1; m_mode = 2; m_match = 0; end
          else m_mode = 1;
        end else m_row = (m_row + 1) % 4;
      end else if (m_mode == 1) begin
        if (low == m_cand % 4) begin
          m_match++;
          if (m_match >= DB) begin deliver = 1; m_mode = 2; m_match = 0; end
        end else begin
          m_match = 0; m_mode = 0; m_row = (m_row + 1) % 4;
        end
      end else begin
        if (samp[m_cand % 4]) begin
          m_match++;
          if (m_match >= DB) begin m_mode = 0; m_match = 0; m_row = (m_row + 1) % 4; end
        end else m_match = 0;
      end
    end
    m_ovr = deliver && m_valid && !acc;
    if (deliver && (!m_valid || acc)) begin
      m_code = m_cand;
      m_valid = 1;
    end else if (acc) m_valid = 0;
  endtask

  // advance one clock and compare every output with the reference
  task automatic tick_cycle();
    int e_row;
    @(posedge clk);
    model_step();
    #1;
    e_row = 15 & ~(1 << m_row);
    chk("row_out", 32'(row_out), 32'(e_row));
    chk("key_valid", 32'(key_valid), 32'(m_valid));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_held", 32'(key_held), 32'(m_mode == 2));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (key_valid && !prev_v) ev_cnt++;
    prev_v = key_valid;
    if (overrun) ov_cnt++;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_row_out", 32'(row_out), 32'(4'b1110));
    chk("rst_key_valid", 32'(key_valid), 32'(0));
    chk("rst_key_code", 32'(key_code), 32'(0));
    chk("rst_key_held", 32'(key_held), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    tick_cycle();
    tick_cycle();
    #3 rst = 1'b0;
  endtask

  task automatic wait_valid(input logic want, input int max, output int n);
    n = 0;
    while (key_valid !== want && n < max) begin tick_cycle(); n++; end
    chk("wait_key_valid", 32'(key_valid), 32'(want));
  endtask

  task automatic wait_held(input logic want, input int max, output int n);
    n = 0;
    while (key_held !== want && n < max) begin tick_cycle(); n++; end
    chk("wait_key_held", 32'(key_held), 32'(want));
  endtask

  task automatic ready_pulse();
    key_ready = 1'b1;
    tick_cycle();
    key_ready = 1'b0;
    chk("accept_clears_valid", 32'(key_valid), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, obase, r, len;
    rst = 1'b1;
    key_ready = 1'b0;
    mask = '0;
    model_reset();
    repeat (3) tick_cycle();
    #3 rst = 1'b0;

    // 1: reset mid-count, then row rotation every ST cycles
    repeat (13) tick_cycle();
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      tick_cycle();
      if (i == 7)  chk("t1_row_pre", 32'(row_out), 32'(4'b1110));
      if (i == 8)  chk("t1_row1", 32'(row_out), 32'(4'b1101));
      if (i == 16) chk("t1_row2", 32'(row_out), 32'(4'b1011));
      if (i == 24) chk("t1_row3", 32'(row_out), 32'(4'b0111));
      if (i == 32) chk("t1_row0", 32'(row_out), 32'(4'b1110));
    end

    // 2: hold key 9, latency bound, release debounce
    mask = 16'(1 << 9);
    wait_valid(1'b1, 80, n);
    chk("t2_latency_le59", 32'(n <= 59), 32'(1));
    chk("t2_code", 32'(key_code), 32'(4'h9));
    chk("t2_held", 32'(key_held), 32'(1));
    mask = '0;
    wait_held(1'b0, 40, n);
    chk("t2_release_window", 32'(n >= 17 && n <= 27), 32'(1));
    chk("t2_valid_kept", 32'(key_valid), 32'(1));
    ready_pulse();

    // 3: bouncing contact on key 9, then stable
    do_reset();
    base = ev_cnt;
    for (int i = 0; i < 8; i++) begin
      mask = (i % 2 == 0) ? 16'(1 << 9) : 16'h0;
      repeat (5) tick_cycle();
    end
    chk("t3_no_bounce_event", 32'(ev_cnt - base), 32'(0));
    mask = 16'(1 << 9);
    repeat (39) tick_cycle();
    chk("t3_valid_before_80", 32'(key_valid), 32'(0));
    tick_cycle();
    chk("t3_valid_at_80", 32'(key_valid), 32'(1));
    chk("t3_code", 32'(key_code), 32'(4'h9));
    repeat (30) tick_cycle();
    chk("t3_single_event", 32'(ev_cnt - base), 32'(1));
    mask = '0;
    wait_held(1'b0, 40, n);
    ready_pulse();

    // 4: overrun when the slot is still full
    do_reset();
    mask = 16'(1 << 5);
    wait_valid(1'b1, 80, n);
    chk("t4_code5", 32'(key_code), 32'(4'h5));
    mask = '0;
    wait_held(1'b0, 40, n);
    obase = ov_cnt;
    mask = 16'(1 << 10);
    wait_held(1'b1, 120, n);
    repeat (3) tick_cycle();
    chk("t4_overrun_once", 32'(ov_cnt - obase), 32'(1));
    chk("t4_code_kept", 32'(key_code), 32'(4'h5));
    chk("t4_valid_kept", 32'(key_valid), 32'(1));
    ready_pulse();
    mask = '0;
    wait_held(1'b0, 40, n);

    // 5: two keys on one row, lowest column wins
    do_reset();
    base = ev_cnt;
    mask = 16'((1 << 4) | (1 << 7));
    wait_valid(1'b1, 80, n);
    chk("t5_code4", 32'(key_code), 32'(4'h4));
    repeat (60) tick_cycle();
    chk("t5_single_event", 32'(ev_cnt - base), 32'(1));
    mask = '0;
    wait_held(1'b0, 40, n);
    ready_pulse();

    // 6: reset during CONFIRM discards the candidate
    do_reset();
    mask = 16'(1 << 9);
    repeat (35) tick_cycle();
    chk("t6_no_valid_yet", 32'(key_valid), 32'(0));
    mask = '0;
    do_reset();
    base = ev_cnt;
    repeat (200) tick_cycle();
    chk("t6_no_event", 32'(ev_cnt - base), 32'(0));
    chk("t6_valid_low", 32'(key_valid), 32'(0));

    // randomized presses, chords and consumer readiness
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      mask = '0;
      else if (r <= 7) mask = 16'(1 << $urandom_range(0, 15));
      else             mask = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
      len = $urandom_range(3, 90);
      for (int k = 0; k < len; k++) begin
        key_ready = ($urandom_range(0, 3) == 0);
        tick_cycle();
      end
    end
    key_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
